// File: rtl/niox_bd_ramdisk_pkg.sv
// niox_bd_ramdisk_pkg
// Shared definitions for the RAM-backed block-device target:
//   - bd_cmd encodings (reset / read / write / reserved)
//   - FSM state codes as they appear in bd_state[3:0]
//   - sector geometry (SECTOR_WORDS 16-bit words per sector)
//   - bd_state layout {3'b0, idx[8:0], state[3:0]} and a packing helper
package niox_bd_ramdisk_pkg;

  localparam int SECTOR_WORDS = 256;
  localparam int IDX_W        = 9;
  localparam int STATE_W      = 4;

  typedef enum logic [1:0] {
    CMD_RESET = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_RSVD  = 2'd3
  } bd_cmd_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 4'd0,
    ST_BUSY  = 4'd1,
    ST_FETCH = 4'd2,
    ST_RXFER = 4'd3,
    ST_WXFER = 4'd4,
    ST_DONE  = 4'd5,
    ST_ERR   = 4'd6
  } bd_state_e;

  // Status word seen by the spy path: word index in the middle, state code low.
  function automatic logic [15:0] pack_state(input logic [IDX_W-1:0] idx,
                                             input bd_state_e        st);
    return {3'b000, idx, st};
  endfunction

endpackage

// File: rtl/niox_bd_ram.sv
// niox_bd_ram
// Single-port synchronous backing store, SECTORS x 256 words x 16 bits.
// Ports:
//   clk      in   clock, posedge
//   reset_n  in   synchronous active-low reset (clears the read register only)
//   we       in   write enable, stores wdata at addr
//   re       in   read enable, rdata <= mem[addr] on the next edge
//   addr     in   word address {sector, word}
//   wdata    in   write data
//   rdata    out  registered read data (1-cycle latency)
module niox_bd_ram
  import niox_bd_ramdisk_pkg::*;
#(
  parameter int SECTORS = 16,
  parameter int AW      = $clog2(SECTORS * SECTOR_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [SECTORS * SECTOR_WORDS];

  // The array itself is never reset so stored sectors survive a reset_n pulse.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Only the output register is reset, so bd_rdata reads 0 after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/niox_bd_ramdisk.sv
// niox_bd_ramdisk
// RAM-backed block-device target for the spy-side bd_* interface. Executes
// reset / read / write sector commands against an internal store of
// SECTORS sectors of 256 16-bit words.
// Optional feature macro: NIOX_BD_RAMDISK_WPROT_EN adds input wprot; a write
// command accepted while wprot=1 ends in ERR without touching the store.
// Ports:
//   clk       in   clock, posedge
//   reset_n   in   synchronous active-low reset
//   wprot     in   write protect (only with NIOX_BD_RAMDISK_WPROT_EN)
//   bd_cmd    in   0=reset 1=read 2=write 3=reserved
//   bd_start  in   level; a command is accepted on its rising edge in IDLE
//   bd_addr   in   sector number
//   bd_wdata  in   write data, taken on bd_wr in WXFER
//   bd_rd     in   read strobe, consumes bd_rdata in RXFER
//   bd_wr     in   write strobe, stores bd_wdata in WXFER
//   bd_rdata  out  current read word
//   bd_bsy    out  command in progress
//   bd_rdy    out  word available (read) / space available (write)
//   bd_err    out  last command failed
//   bd_iordy  out  low only during the BUSY latency window
//   bd_state  out  {3'b0, idx[8:0], state[3:0]}
module niox_bd_ramdisk
  import niox_bd_ramdisk_pkg::*;
#(
  parameter int SECTORS = 16,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef NIOX_BD_RAMDISK_WPROT_EN
  input  logic        wprot,
`endif
  input  logic [1:0]  bd_cmd,
  input  logic        bd_start,
  input  logic [23:0] bd_addr,
  input  logic [15:0] bd_wdata,
  input  logic        bd_rd,
  input  logic        bd_wr,
  output logic [15:0] bd_rdata,
  output logic        bd_bsy,
  output logic        bd_rdy,
  output logic        bd_err,
  output logic        bd_iordy,
  output logic [15:0] bd_state
);

  localparam int AW    = $clog2(SECTORS * SECTOR_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  bd_state_e        state_q, state_d;
  bd_cmd_e          cmd_q, cmd_d;
  logic [23:0]      addr_q, addr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             start_q;

  logic             accept;
  logic             cmd_bad;
  logic             last_word;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    ram_addr;

  assign accept    = (state_q == ST_IDLE) && bd_start && !start_q;
  assign last_word = (idx_q[7:0] == 8'hFF);

  // Commands are validated at accept time so a bad one skips the BUSY latency.
`ifdef NIOX_BD_RAMDISK_WPROT_EN
  assign cmd_bad = (bd_cmd == CMD_RSVD) ||
                   (32'(bd_addr) >= 32'(SECTORS)) ||
                   ((bd_cmd == CMD_WRITE) && wprot);
`else
  assign cmd_bad = (bd_cmd == CMD_RSVD) ||
                   (32'(bd_addr) >= 32'(SECTORS));
`endif

  // Sector number is already range-checked, so truncation only drops zeros.
  assign ram_addr = AW'({addr_q, idx_q[7:0]});

  // Next-state and datapath updates for the command sequencer.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    ram_re  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d   = bd_cmd_e'(bd_cmd);
          addr_d  = bd_addr;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = cmd_bad;
          state_d = cmd_bad ? ST_ERR : ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          case (cmd_q)
            CMD_READ:  state_d = ST_FETCH;
            CMD_WRITE: state_d = ST_WXFER;
            default:   state_d = ST_DONE;
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FETCH: begin
        ram_re  = 1'b1;
        state_d = ST_RXFER;
      end

      ST_RXFER: begin
        if (bd_rd) begin
          idx_d   = idx_q + 9'd1;
          state_d = last_word ? ST_DONE : ST_FETCH;
        end
      end

      ST_WXFER: begin
        if (bd_wr) begin
          ram_we = 1'b1;
          idx_d  = idx_q + 9'd1;
          if (last_word) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE, ST_ERR: begin
        if (!bd_start) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer back to IDLE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_RESET;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      start_q <= bd_start;
    end
  end

  // Write enable is gated by reset_n so an aborting reset never lands a word.
  niox_bd_ram #(
    .SECTORS (SECTORS),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (ram_we && reset_n),
    .re      (ram_re),
    .addr    (ram_addr),
    .wdata   (bd_wdata),
    .rdata   (bd_rdata)
  );

  assign bd_bsy   = (state_q == ST_BUSY)  || (state_q == ST_FETCH) ||
                    (state_q == ST_RXFER) || (state_q == ST_WXFER);
  assign bd_rdy   = (state_q == ST_RXFER) || (state_q == ST_WXFER);
  assign bd_err   = err_q;
  assign bd_iordy = (state_q != ST_BUSY);
  assign bd_state = pack_state(idx_q, state_q);

endmodule

// File: tb/tb_niox_bd_ramdisk.sv
// tb_niox_bd_ramdisk
// Directed bench for niox_bd_ramdisk (SECTORS=16, LATENCY=4): a table of
// non-transfer commands plus hand-written write/read/abort sequences.
module tb_niox_bd_ramdisk;

  localparam int SECTORS = 16;
  localparam int LATENCY = 4;

  logic        clk;
  logic        reset_n;
  logic        wprot;
  logic [1:0]  bd_cmd;
  logic        bd_start;
  logic [23:0] bd_addr;
  logic [15:0] bd_wdata;
  logic        bd_rd;
  logic        bd_wr;
  logic [15:0] bd_rdata;
  logic        bd_bsy;
  logic        bd_rdy;
  logic        bd_err;
  logic        bd_iordy;
  logic [15:0] bd_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] model [SECTORS*256];

  typedef struct {
    logic [1:0]  cmd;
    logic [23:0] addr;
    logic [3:0]  exp_state;
    logic        exp_err;
    int          exp_cycles;
    int          exp_bsy;
  } vec_t;

  vec_t vecs [7];

  niox_bd_ramdisk #(
    .SECTORS (SECTORS),
    .LATENCY (LATENCY)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef NIOX_BD_RAMDISK_WPROT_EN
    .wprot    (wprot),
`endif
    .bd_cmd   (bd_cmd),
    .bd_start (bd_start),
    .bd_addr  (bd_addr),
    .bd_wdata (bd_wdata),
    .bd_rd    (bd_rd),
    .bd_wr    (bd_wr),
    .bd_rdata (bd_rdata),
    .bd_bsy   (bd_bsy),
    .bd_rdy   (bd_rdy),
    .bd_err   (bd_err),
    .bd_iordy (bd_iordy),
    .bd_state (bd_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic startCmd(input logic [1:0] c, input logic [23:0] a);
    @(negedge clk);
    bd_cmd   = c;
    bd_addr  = a;
    bd_start = 1'b1;
  endtask

  task automatic finishCmd(input string name);
    bd_start = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("%s_idle", name), {28'd0, bd_state[3:0]}, 32'd0);
  endtask

  task automatic waitRdy(input string name, input int exp_cyc);
    int  cyc  = 0;
    bit  seen = 1'b0;
    for (int k = 1; k <= 64 && !seen; k++) begin
      @(negedge clk);
      if (bd_rdy) begin
        seen = 1'b1;
        cyc  = k;
      end
    end
    checkOutput($sformatf("%s_rdy_latency", name), cyc, exp_cyc);
  endtask

  // One table entry: command without data transfer, ending in DONE or ERR.
  task automatic applyStimulus(input vec_t v, input int n);
    int bsy_cnt   = 0;
    int iordy_cnt = 0;
    int cyc       = 0;
    bit done      = 1'b0;
    startCmd(v.cmd, v.addr);
    for (int k = 1; k <= 50 && !done; k++) begin
      @(negedge clk);
      if (bd_bsy)    bsy_cnt++;
      if (!bd_iordy) iordy_cnt++;
      if (bd_state[3:0] == 4'd5 || bd_state[3:0] == 4'd6) begin
        done = 1'b1;
        cyc  = k;
      end
    end
    checkOutput($sformatf("vec%0d_cycles", n), cyc, v.exp_cycles);
    checkOutput($sformatf("vec%0d_state", n), {16'd0, bd_state}, {28'd0, v.exp_state});
    checkOutput($sformatf("vec%0d_err", n), {31'd0, bd_err}, {31'd0, v.exp_err});
    checkOutput($sformatf("vec%0d_bsy_cycles", n), bsy_cnt, v.exp_bsy);
    checkOutput($sformatf("vec%0d_iordy_low", n), iordy_cnt, v.exp_bsy);
    checkOutput($sformatf("vec%0d_bsy_end", n), {31'd0, bd_bsy}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput($sformatf("vec%0d_held_start", n), {16'd0, bd_state}, {28'd0, v.exp_state});
    finishCmd($sformatf("vec%0d", n));
    checkOutput($sformatf("vec%0d_err_idle", n), {31'd0, bd_err}, {31'd0, v.exp_err});
  endtask

  task automatic writeWords(input int sector, input logic [15:0] base,
                            input int count, input bit full);
    int drops = 0;
    startCmd(2'd2, 24'(sector));
    waitRdy($sformatf("wr%0d", sector), LATENCY + 1);
    for (int i = 0; i < count; i++) begin
      if (i > 0) @(negedge clk);
      if (!bd_rdy) drops++;
      bd_wr    = 1'b1;
      bd_wdata = base + 16'(i);
      model[sector*256 + i] = base + 16'(i);
    end
    @(negedge clk);
    bd_wr = 1'b0;
    checkOutput($sformatf("wr%0d_rdy_drops", sector), drops, 0);
    if (full) begin
      checkOutput($sformatf("wr%0d_done_state", sector), {16'd0, bd_state}, 32'h1005);
      checkOutput($sformatf("wr%0d_err", sector), {31'd0, bd_err}, 32'd0);
      finishCmd($sformatf("wr%0d", sector));
    end
  endtask

  // Holds bd_rd high throughout; optionally also holds bd_wr to prove it is ignored.
  task automatic readSector(input int sector, input bit inject_wr, input string name);
    int words  = 0;
    int viol   = 0;
    int done_k = -1;
    bit done   = 1'b0;
    startCmd(2'd1, 24'(sector));
    waitRdy(name, LATENCY + 2);
    for (int k = 0; k < 1200 && !done; k++) begin
      if (k > 0) @(negedge clk);
      if (bd_state[3:0] == 4'd5) begin
        done   = 1'b1;
        done_k = k;
      end else begin
        if (bd_rdy) begin
          if (words < 256)
            checkOutput($sformatf("%s_w%0d", name, words), {16'd0, bd_rdata},
                        {16'd0, model[sector*256 + words]});
          words++;
        end
        if (bd_state[3:0] == 4'd2 && bd_rdy) viol++;
        bd_rd    = 1'b1;
        bd_wr    = inject_wr;
        bd_wdata = 16'hDEAD;
      end
    end
    bd_rd = 1'b0;
    bd_wr = 1'b0;
    checkOutput($sformatf("%s_words", name), words, 256);
    checkOutput($sformatf("%s_done_cycle", name), done_k, 511);
    checkOutput($sformatf("%s_fetch_rdy", name), viol, 0);
    checkOutput($sformatf("%s_done_state", name), {16'd0, bd_state}, 32'h1005);
    checkOutput($sformatf("%s_err", name), {31'd0, bd_err}, 32'd0);
    finishCmd(name);
  endtask

  initial begin
    // {cmd, addr, final state, err, cycles accept->final, busy cycles}
    vecs[0] = '{2'd0, 24'd0,       4'd5, 1'b0, LATENCY + 1, LATENCY};
    vecs[1] = '{2'd1, 24'd16,      4'd6, 1'b1, 1,           0};
    vecs[2] = '{2'd0, 24'd2,       4'd5, 1'b0, LATENCY + 1, LATENCY};
    vecs[3] = '{2'd3, 24'd0,       4'd6, 1'b1, 1,           0};
    vecs[4] = '{2'd2, 24'hFFFFFF,  4'd6, 1'b1, 1,           0};
    vecs[5] = '{2'd0, 24'd15,      4'd5, 1'b0, LATENCY + 1, LATENCY};
    vecs[6] = '{2'd0, 24'd16,      4'd6, 1'b1, 1,           0};

    reset_n  = 1'b0;
    wprot    = 1'b0;
    bd_cmd   = 2'd0;
    bd_start = 1'b0;
    bd_addr  = 24'd0;
    bd_wdata = 16'd0;
    bd_rd    = 1'b0;
    bd_wr    = 1'b0;

    $display("[TB] reset checks");
    repeat (2) @(negedge clk);
    checkOutput("rst_state", {16'd0, bd_state}, 32'h0);
    checkOutput("rst_bsy",   {31'd0, bd_bsy},   32'd0);
    checkOutput("rst_rdy",   {31'd0, bd_rdy},   32'd0);
    checkOutput("rst_err",   {31'd0, bd_err},   32'd0);
    checkOutput("rst_iordy", {31'd0, bd_iordy}, 32'd1);
    checkOutput("rst_rdata", {16'd0, bd_rdata}, 32'd0);
    reset_n = 1'b1;

    $display("[TB] command table");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i], i);

    $display("[TB] write then read sector 3");
    writeWords(3, 16'hA000, 256, 1'b1);
    readSector(3, 1'b1, "rd3");
    readSector(3, 1'b0, "rd3b");

    $display("[TB] reset abort during sector 1 write");
    writeWords(1, 16'hB000, 256, 1'b1);
    writeWords(1, 16'hC000, 100, 1'b0);
    checkOutput("abort_pre_state", {16'd0, bd_state}, 32'h0644);
    reset_n  = 1'b0;
    bd_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("abort_state", {16'd0, bd_state}, 32'h0);
    checkOutput("abort_bsy",   {31'd0, bd_bsy},   32'd0);
    checkOutput("abort_rdy",   {31'd0, bd_rdy},   32'd0);
    checkOutput("abort_iordy", {31'd0, bd_iordy}, 32'd1);
    readSector(1, 1'b0, "rd1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
